polaris_cpu: RTL and testbench

POLARIS_CPU -- requirements
Module: polaris_cpu

---
 rtl/polaris_cpu.sv | 270 +++++++++++++++++++++++++++
 tb/tb_polaris_cpu.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/polaris_cpu.sv
// polaris_cpu: multi-cycle RV64I subset core (LUI/AUIPC/OP-IMM/OP/JALR).
// Define POLARIS_RV64W_EN to add OP-IMM-32 (ADDIW/SLLIW/SRLIW/SRAIW).
module polaris_cpu (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        iack_i,
   input  logic [31:0] idat_i,
   output logic [63:0] iadr_o,
   output logic [1:0]  isiz_o,
   output logic        jammed_o
);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_XT0, S_XT1, S_XT2, S_XT3, S_JAM
   } state_e;

   typedef enum logic [3:0] {
      A_ADD, A_SUB, A_SLL, A_SLT, A_SLTU,
      A_XOR, A_SRL, A_SRA, A_OR, A_AND
   } aluop_e;

   localparam logic [63:0] RESET_PC = 64'hFFFF_FFFF_FFFF_FF00;
   localparam logic [6:0]  OP_LUI   = 7'b0110111;
   localparam logic [6:0]  OP_AUIPC = 7'b0010111;
   localparam logic [6:0]  OP_IMM   = 7'b0010011;
   localparam logic [6:0]  OP_OP    = 7'b0110011;
   localparam logic [6:0]  OP_JALR  = 7'b1100111;
   localparam logic [6:0]  OP_IMM32 = 7'b0011011;

   state_e      state_q, state_d;
   logic [63:0] pc_q, pc_d;
   logic [63:0] ia_q, ia_d;
   logic [31:0] ir_q, ir_d;
   logic [63:0] a_q, a_d;
   logic [63:0] b_q, b_d;
   logic [63:0] r_q, r_d;

   logic [63:0] rf_q [0:31];
   logic        rf_we;
   logic [63:0] rf_wd;

   logic [6:0]  opc;
   logic [4:0]  rd, rs1, rs2;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic [63:0] imm_i, imm_u;
   logic [63:0] rs1_val, rs2_val;

   assign opc = ir_q[6:0];
   assign rd  = ir_q[11:7];
   assign f3  = ir_q[14:12];
   assign rs1 = ir_q[19:15];
   assign rs2 = ir_q[24:20];
   assign f7  = ir_q[31:25];

   assign imm_i = {{52{ir_q[31]}}, ir_q[31:20]};
   assign imm_u = {{32{ir_q[31]}}, ir_q[31:12], 12'b0};

   assign rs1_val = (rs1 == 5'd0) ? 64'd0 : rf_q[rs1];
   assign rs2_val = (rs2 == 5'd0) ? 64'd0 : rf_q[rs2];

   logic is_lui, is_auipc, is_opimm, is_op, is_jalr, is_w;
   logic opimm_ok, op_ok, w_ok, legal;

   assign is_lui   = (opc == OP_LUI);
   assign is_auipc = (opc == OP_AUIPC);
   assign is_opimm = (opc == OP_IMM);
   assign is_op    = (opc == OP_OP);
   assign is_jalr  = (opc == OP_JALR);

`ifdef POLARIS_RV64W_EN
   assign is_w = (opc == OP_IMM32);
`else
   assign is_w = 1'b0;
`endif

   // Shift immediates carry funct6 (64-bit) or funct7 (W-form) above shamt
   assign opimm_ok =
      (f3 == 3'b001) ? (f7[6:1] == 6'b000000) :
      (f3 == 3'b101) ? (f7[6:1] == 6'b000000 ||
                        f7[6:1] == 6'b010000) :
      1'b1;

   assign op_ok =
      (f7 == 7'b0000000) ||
      (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));

   assign w_ok =
      (f3 == 3'b000) ||
      (f3 == 3'b001 && f7 == 7'b0000000) ||
      (f3 == 3'b101 && (f7 == 7'b0000000 ||
                        f7 == 7'b0100000));

   always_comb begin
      legal = 1'b0;
      unique case (1'b1)
         is_lui, is_auipc: legal = 1'b1;
         is_opimm:         legal = opimm_ok;
         is_op:            legal = op_ok;
         is_jalr:          legal = (f3 == 3'b000);
         is_w:             legal = w_ok;
         default:          legal = 1'b0;
      endcase
   end

   aluop_e aluop;

   always_comb begin
      aluop = A_ADD;
      if (is_op || is_opimm || is_w) begin
         unique case (f3)
            3'b000: aluop = (is_op && ir_q[30]) ? A_SUB : A_ADD;
            3'b001: aluop = A_SLL;
            3'b010: aluop = A_SLT;
            3'b011: aluop = A_SLTU;
            3'b100: aluop = A_XOR;
            3'b101: aluop = ir_q[30] ? A_SRA : A_SRL;
            3'b110: aluop = A_OR;
            3'b111: aluop = A_AND;
            default: aluop = A_ADD;
         endcase
      end
   end

   logic        sub_en;
   logic [63:0] b_eff;
   logic [64:0] sum;
   logic        alu_c, alu_v, alu_z;
   logic [5:0]  shamt;
   logic [63:0] res64, alu_res;

   assign sub_en = (aluop == A_SUB) || (aluop == A_SLT) ||
                   (aluop == A_SLTU);
   assign b_eff  = sub_en ? ~b_q : b_q;
   assign sum    = {1'b0, a_q} + {1'b0, b_eff} + {64'd0, sub_en};
   assign alu_c  = sum[64];
   assign alu_v  = (a_q[63] == b_eff[63]) && (sum[63] != a_q[63]);
   assign alu_z  = (sum[63:0] == 64'd0);
   assign shamt  = b_q[5:0];

   // Equal operands give z=1, which also forces both compares to 0
   always_comb begin
      res64 = sum[63:0];
      unique case (aluop)
         A_ADD, A_SUB: res64 = sum[63:0];
         A_SLL:  res64 = a_q << shamt;
         A_SLT:  res64 = {63'd0, (sum[63] ^ alu_v) & ~alu_z};
         A_SLTU: res64 = {63'd0, ~alu_c & ~alu_z};
         A_XOR:  res64 = a_q ^ b_q;
         A_SRL:  res64 = a_q >> shamt;
         A_SRA:  res64 = $signed(a_q) >>> shamt;
         A_OR:   res64 = a_q | b_q;
         A_AND:  res64 = a_q & b_q;
         default: res64 = sum[63:0];
      endcase
   end

`ifdef POLARIS_RV64W_EN
   logic [31:0] w32;

   always_comb begin
      w32 = sum[31:0];
      case (aluop)
         A_SLL:   w32 = a_q[31:0] << b_q[4:0];
         A_SRL:   w32 = a_q[31:0] >> b_q[4:0];
         A_SRA:   w32 = $signed(a_q[31:0]) >>> b_q[4:0];
         default: w32 = sum[31:0];
      endcase
   end

   assign alu_res = is_w ? {{32{w32[31]}}, w32} : res64;
`else
   assign alu_res = res64;
`endif

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ia_d    = ia_q;
      ir_d    = ir_q;
      a_d     = a_q;
      b_d     = b_q;
      r_d     = r_q;
      rf_we   = 1'b0;
      rf_wd   = 64'd0;
      unique case (state_q)
         S_IDLE: state_d = S_FETCH;
         S_FETCH: begin
            if (iack_i) begin
               ir_d    = idat_i;
               ia_d    = pc_q;
               pc_d    = pc_q + 64'd4;
               state_d = S_XT0;
            end
         end
         S_XT0: begin
            a_d     = rs1_val;
            state_d = legal ? S_XT1 : S_JAM;
         end
         S_XT1: begin
            b_d = is_op ? rs2_val : imm_i;
            if (is_lui || is_auipc) begin
               rf_we   = 1'b1;
               rf_wd   = is_lui ? imm_u : ia_q + imm_u;
               state_d = S_FETCH;
            end else begin
               state_d = S_XT2;
            end
         end
         S_XT2: begin
            r_d = alu_res;
            if (is_op || is_jalr) begin
               state_d = S_XT3;
            end else begin
               rf_we   = 1'b1;
               rf_wd   = alu_res;
               state_d = S_FETCH;
            end
         end
         S_XT3: begin
            rf_we   = 1'b1;
            rf_wd   = is_jalr ? pc_q : r_q;
            state_d = S_FETCH;
            if (is_jalr) begin
               pc_d = {r_q[63:1], 1'b0};
            end
         end
         S_JAM:   state_d = S_JAM;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_PC;
         ia_q    <= 64'd0;
         ir_q    <= 32'd0;
         a_q     <= 64'd0;
         b_q     <= 64'd0;
         r_q     <= 64'd0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ia_q    <= ia_d;
         ir_q    <= ir_d;
         a_q     <= a_d;
         b_q     <= b_d;
         r_q     <= r_d;
      end
   end

   // Register file holds its contents across reset
   always_ff @(posedge clk_i) begin
      if (rf_we && rd != 5'd0) begin
         rf_q[rd] <= rf_wd;
      end
   end

   always_comb begin
      iadr_o   = 64'd0;
      isiz_o   = 2'b00;
      jammed_o = (state_q == S_JAM);
      if (state_q == S_FETCH) begin
         iadr_o = pc_q;
         isiz_o = 2'b10;
      end
   end

endmodule

// File: tb/tb_polaris_cpu.sv
// tb_polaris_cpu: directed program checks of fetch addresses and cycle counts.
// W-form test runs when POLARIS_RV64W_EN is defined, else checks it jams.
module tb_polaris_cpu;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        iack = 1'b0;
   logic [31:0] idat = 32'd0;
   logic [63:0] iadr;
   logic [1:0]  isiz;
   logic        jam;

   int          tests = 0;
   int          fails = 0;
   logic [63:0] epc;

   localparam logic [63:0] RPC = 64'hFFFF_FFFF_FFFF_FF00;

   polaris_cpu dut (
      .clk_i    (clk),
      .reset_i  (rst_n),
      .iack_i   (iack),
      .idat_i   (idat),
      .iadr_o   (iadr),
      .isiz_o   (isiz),
      .jammed_o (jam)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] enc_i(int imm, int rs1, int f3,
                                         int rd, int op);
      return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
   endfunction

   function automatic logic [31:0] enc_r(int f7, int rs2, int rs1,
                                         int f3, int rd);
      return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
   endfunction

   function automatic logic [31:0] enc_u(int imm, int rd, int op);
      return {imm[19:0], rd[4:0], op[6:0]};
   endfunction

   function automatic logic [31:0] addi(int rd, int rs1, int imm);
      return enc_i(imm, rs1, 0, rd, 'h13);
   endfunction

   function automatic logic [31:0] jalr(int rd, int rs1, int imm);
      return enc_i(imm, rs1, 0, rd, 'h67);
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wait_fetch(input string tag);
      int n = 0;
      while (isiz !== 2'b10 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (isiz !== 2'b10)
         chk({tag, " fetch timeout"}, 64'(isiz), 64'd2);
   endtask

   task automatic run(input string tag, input logic [31:0] ins,
                      input int cyc);
      int n;
      wait_fetch(tag);
      chk({tag, " adr"}, iadr, epc);
      iack = 1'b1;
      idat = ins;
      @(negedge clk);
      iack = 1'b0;
      idat = 32'd0;
      n = 1;
      while (isiz !== 2'b10 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk({tag, " cyc"}, 64'(n), 64'(cyc));
      epc += 64'd4;
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      @(negedge clk);
      chk("rst jam", 64'(jam), 64'd0);
      chk("rst isiz", 64'(isiz), 64'd0);
      rst_n = 1'b1;
      epc = RPC;
   endtask

   task automatic expect_jam(input string tag, input logic [31:0] ins);
      wait_fetch(tag);
      chk({tag, " adr"}, iadr, epc);
      iack = 1'b1;
      idat = ins;
      @(negedge clk);
      iack = 1'b0;
      idat = 32'd0;
      chk({tag, " xt0 jam"}, 64'(jam), 64'd0);
      chk({tag, " xt0 isiz"}, 64'(isiz), 64'd0);
      @(negedge clk);
      chk({tag, " jam"}, 64'(jam), 64'd1);
      repeat (3) @(negedge clk);
      chk({tag, " hold jam"}, 64'(jam), 64'd1);
      chk({tag, " hold isiz"}, 64'(isiz), 64'd0);
      chk({tag, " hold iadr"}, iadr, 64'd0);
      pulse_reset();
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("reset isiz", 64'(isiz), 64'd0);
      chk("reset iadr", iadr, 64'd0);
      chk("reset jam", 64'(jam), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         chk("wait isiz", 64'(isiz), 64'd2);
         chk("wait iadr", iadr, RPC);
         @(negedge clk);
      end
      epc = RPC;
      expect_jam("zero word", 32'h0000_0000);

      run("nop", 32'h0000_0013, 4);
      run("addi x2", addi(2, 0, 'h124), 4);
      run("jalr x2", jalr(0, 2, 0), 5);
      epc = 64'h124;
      run("addi x2+", addi(2, 2, 'h124), 4);
      run("jalr x1", jalr(1, 2, 0), 5);
      epc = 64'h248;
      run("jalr -4", jalr(0, 1, 'hFFC), 5);
      epc = 64'h128;

      run("andi", enc_i(255, 2, 7, 2, 'h13), 4);
      run("slli16", enc_i(16, 2, 1, 2, 'h13), 4);
      run("jalr 48", jalr(0, 2, 0), 5);
      epc = 64'h0048_0000;

`ifdef POLARIS_RV64W_EN
      run("addi x3", addi(3, 0, 1), 4);
      run("slliw", enc_i(31, 3, 1, 3, 'h1B), 4);
      run("jalr w", jalr(0, 3, 0), 5);
      epc = 64'hFFFF_FFFF_8000_0000;
`endif

      run("lui x3", enc_u('h80000, 3, 'h37), 3);
      run("srai", enc_i('h404, 3, 5, 7, 'h13), 4);
      run("slt", enc_r(0, 0, 3, 2, 8), 5);
      run("sltu", enc_r(0, 3, 0, 3, 9), 5);
      run("sltu0", enc_r(0, 0, 3, 3, 10), 5);
      run("add8", enc_r(0, 8, 7, 0, 7), 5);
      run("add9", enc_r(0, 9, 7, 0, 7), 5);
      run("add10", enc_r(0, 10, 7, 0, 7), 5);
      run("jalr cmp", jalr(0, 7, 0), 5);
      epc = 64'hFFFF_FFFF_F800_0002;
      run("sub", enc_r('h20, 7, 0, 0, 10), 5);
      run("srli", enc_i(36, 3, 5, 11, 'h13), 4);
      run("and", enc_r(0, 11, 10, 7, 12), 5);
      run("or", enc_r(0, 8, 12, 6, 13), 5);
      run("jalr or", jalr(0, 13, 0), 5);
      // OR sets bit 0, which JALR clears
      epc = 64'h0000_0000_07FF_FFFE;

      run("x4 555", addi(4, 0, 'h555), 4);
      run("x4 sll4", enc_i(4, 4, 1, 4, 'h13), 4);
      run("x4 ori", enc_i(5, 4, 6, 4, 'h13), 4);
      run("x5 ones", addi(5, 0, 'hFFF), 4);
      run("x5 srl48", enc_i(48, 5, 5, 5, 'h13), 4);
      run("xor x6", enc_r(0, 5, 4, 4, 6), 5);
      run("x4 sll16", enc_i(16, 4, 1, 4, 'h13), 4);
      run("xor x4", enc_r(0, 6, 4, 4, 4), 5);
      run("x4 sll16b", enc_i(16, 4, 1, 4, 'h13), 4);
      run("x2 ones", addi(2, 0, 'hFFF), 4);
      run("xor x2", enc_r(0, 4, 2, 4, 2), 5);
      run("jalr pat", jalr(0, 2, 0), 5);
      epc = 64'hFFFF_AAAA_5555_FFFE;

      run("lui dead", enc_u('hDEADB, 2, 'h37), 3);
      run("jalr lui", jalr(0, 2, 0), 5);
      epc = 64'hFFFF_FFFF_DEAD_B000;
      run("auipc", enc_u('h00524, 5, 'h17), 3);
      run("jalr auipc", jalr(0, 5, 0), 5);
      epc = 64'hFFFF_FFFF_DEFF_F000;

      // Abort an ADDI in its write cycle; x2 must keep the LUI value
      wait_fetch("abort");
      chk("abort adr", iadr, epc);
      iack = 1'b1;
      idat = addi(2, 0, 'h555);
      @(negedge clk);
      iack = 1'b0;
      idat = 32'd0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort isiz", 64'(isiz), 64'd0);
      rst_n = 1'b1;
      epc = RPC;
      run("jalr keep", jalr(0, 2, 0), 5);
      epc = 64'hFFFF_FFFF_DEAD_B000;

      expect_jam("bad funct7", enc_r('h20, 1, 1, 1, 1));
      expect_jam("bad opcode", 32'h0000_007F);
`ifndef POLARIS_RV64W_EN
      expect_jam("w disabled", enc_i(31, 3, 1, 3, 'h1B));
`endif

      wait_fetch("end");
      chk("end adr", iadr, epc);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
